// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// - Operation codes are the same ones the combinational ALU decodes.
// - FSM state encoding for the iterative engine.
// - Iteration counter width.
package hilo_muldiv_unit_pkg;

  localparam logic [3:0] OP_MULT = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;

  // Wide enough to count ITERS = 32 iterations.
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } muldivState_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative datapath shared by multiply and divide.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   load          initialise: acc = {0, initLow}, latch operand
//   step          perform one iteration (shift-add or restore-subtract)
//   isDiv         selects restoring divide instead of shift-add multiply
//   operand       multiplicand (multiply) or divisor (divide), magnitude only
//   initLow       multiplier (multiply) or dividend (divide), magnitude only
//   acc           2*WIDTH accumulator; {HI,LO} product or {remainder,quotient}
module muldiv_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               isDiv,
  input  logic [WIDTH-1:0]   operand,
  input  logic [WIDTH-1:0]   initLow,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] accQ, accD;
  logic [WIDTH-1:0]   opQ;
  logic [WIDTH:0]     addSum;
  logic [WIDTH:0]     remShift;
  logic [WIDTH+1:0]   diff;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current multiplier
    // bit (acc[0]) is set, keeping the carry so the right shift retains it.
    addSum   = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, opQ} : '0);
    // Divide: partial remainder shifted left by one, pulling in the next dividend bit.
    remShift = accQ[2*WIDTH-1:WIDTH-1];
    diff     = {1'b0, remShift} - {2'b00, opQ};

    accD = accQ;
    if (load) begin
      accD = {{WIDTH{1'b0}}, initLow};
    end else if (step) begin
      if (isDiv) begin
        if (!diff[WIDTH+1]) begin
          accD = {diff[WIDTH-1:0], accQ[WIDTH-2:0], 1'b1};
        end else begin
          accD = {accQ[2*WIDTH-2:0], 1'b0};
        end
      end else begin
        accD = {addSum, accQ[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accQ <= '0;
      opQ  <= '0;
    end else begin
      accQ <= accD;
      if (load) begin
        opQ <= operand;
      end
    end
  end

  assign acc = accQ;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide engine owning the architectural HI/LO pair.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, operation    issue request; OP_MULT / OP_DIV, anything else ignored
//   sign                sign[1] selects signed arithmetic; sign[0] unused
//   A, B                multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata   direct writes into HI / LO (accepted only when idle)
//   rd_hi, rd_lo        mfhi/mflo present in EX (used only for stall)
//   hi_out, lo_out      HI / LO registers
//   busy                operation in flight
//   done, div_zero      one-cycle pulses after HI/LO are written by an operation
//   stall               busy and something in EX needs HI/LO or the engine
// Latency is fixed: PREP (1) + ITER (ITERS) + FIX (1) cycles. ITERS must equal WIDTH.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [1:0]       sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(ITERS - 1);

  muldivState_e stateQ, stateD;

  logic [CNT_W-1:0]   cntQ;
  logic [WIDTH-1:0]   aQ, bQ;
  logic               isDivQ, signedQ;
  logic               negQuotQ, negRemQ;
  logic [WIDTH-1:0]   hiQ, hiD, loQ, loD;
  logic               doneQ, divZeroQ;

  logic               validStart;
  logic               aNeg, bNeg;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH-1:0]   coreOperand, coreInitLow;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   resHi, resLo;
  logic               unusedSign;

  assign unusedSign = sign[0];

  assign validStart = start && ((operation == OP_MULT) || (operation == OP_DIV));

  // Operand magnitudes and result signs are derived from the latched operands.
  assign aNeg = signedQ & aQ[WIDTH-1];
  assign bNeg = signedQ & bQ[WIDTH-1];
  assign absA = aNeg ? (-aQ) : aQ;
  assign absB = bNeg ? (-bQ) : bQ;

  assign coreOperand = isDivQ ? absB : absA;
  assign coreInitLow = isDivQ ? absA : absB;

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (stateQ == S_PREP),
    .step    (stateQ == S_ITER),
    .isDiv   (isDivQ),
    .operand (coreOperand),
    .initLow (coreInitLow),
    .acc     (acc)
  );

  // Sign fix-up of the magnitude result. Divide by zero bypasses the core result.
  always_comb begin
    prodFix = negQuotQ ? (-acc) : acc;
    quot    = acc[WIDTH-1:0];
    rem     = acc[2*WIDTH-1:WIDTH];
    if (isDivQ) begin
      if (bQ == '0) begin
        resHi = aQ;
        resLo = '1;
      end else begin
        resHi = negRemQ ? (-rem) : rem;
        resLo = negQuotQ ? (-quot) : quot;
      end
    end else begin
      resHi = prodFix[2*WIDTH-1:WIDTH];
      resLo = prodFix[WIDTH-1:0];
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      S_IDLE:  if (validStart) stateD = S_PREP;
      S_PREP:  stateD = S_ITER;
      S_ITER:  if (cntQ == LastIter) stateD = S_FIX;
      S_FIX:   stateD = S_IDLE;
      default: stateD = S_IDLE;
    endcase
  end

  // HI/LO only move on an idle mthi/mtlo or on the FIX edge. A write issued in
  // the same cycle as start lands now and is overwritten by the result later.
  always_comb begin
    hiD = hiQ;
    loD = loQ;
    if (stateQ == S_IDLE) begin
      if (mthi) hiD = wdata;
      if (mtlo) loD = wdata;
    end else if (stateQ == S_FIX) begin
      hiD = resHi;
      loD = resLo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= S_IDLE;
      cntQ     <= '0;
      aQ       <= '0;
      bQ       <= '0;
      isDivQ   <= 1'b0;
      signedQ  <= 1'b0;
      negQuotQ <= 1'b0;
      negRemQ  <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
      doneQ    <= 1'b0;
      divZeroQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      hiQ      <= hiD;
      loQ      <= loD;
      doneQ    <= (stateQ == S_FIX);
      divZeroQ <= (stateQ == S_FIX) && isDivQ && (bQ == '0);
      if ((stateQ == S_IDLE) && validStart) begin
        aQ      <= A;
        bQ      <= B;
        isDivQ  <= (operation == OP_DIV);
        signedQ <= sign[1];
      end
      if (stateQ == S_PREP) begin
        cntQ     <= '0;
        negQuotQ <= aNeg ^ bNeg;
        negRemQ  <= aNeg;
      end
      if (stateQ == S_ITER) begin
        cntQ <= cntQ + CNT_W'(1);
      end
    end
  end

  assign busy     = (stateQ != S_IDLE);
  assign stall    = busy & (rd_hi | rd_lo | mthi | mtlo | start);
  assign hi_out   = hiQ;
  assign lo_out   = loQ;
  assign done     = doneQ;
  assign div_zero = divZeroQ;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases, hazards,
// mid-operation reset, then randomized operations against an arithmetic model.
module tb_hilo_muldiv_unit;

  localparam logic [3:0] MULT = 4'b0010;
  localparam logic [3:0] DIV  = 4'b0011;
  localparam int LATENCY = 34;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  operation;
  logic [1:0]  sign;
  logic [31:0] A, B;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        rd_hi, rd_lo;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero, stall;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operation (operation),
    .sign      (sign),
    .A         (A),
    .B         (B),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .rd_hi     (rd_hi),
    .rd_lo     (rd_lo),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .stall     (stall)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Expected {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] refModel(input logic [3:0] op, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == MULT) begin
      if (sgn) return 64'(sa * sb);
      return ua * ub;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  // Drive a request so it is sampled at the next edge (E0); return #1 after E0.
  task automatic startOp(input logic [3:0] op, input logic [1:0] sgn,
                         input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; operation = op; sign = sgn; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; operation = 4'd0; mthi = 1'b0; mtlo = 1'b0;
    A = $urandom; B = $urandom;
  endtask

  // Continue from sample index i0 (samples are #1 after each edge, index 0 = E0).
  task automatic finishOp(input string tag, input logic [3:0] op, input logic [1:0] sgn,
                          input logic [31:0] a, input logic [31:0] b, input int i0);
    int lat = -1;
    int busyCnt = i0;
    logic [63:0] exp;
    exp = refModel(op, sgn[1], a, b);
    for (int i = i0; i < LATENCY + 20; i++) begin
      if (busy) busyCnt++;
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    checkVal({tag, " latency"}, 64'(lat), 64'(LATENCY));
    checkVal({tag, " busy cycles"}, 64'(busyCnt), 64'(LATENCY));
    checkVal({tag, " hi"}, {32'd0, hi_out}, {32'd0, exp[63:32]});
    checkVal({tag, " lo"}, {32'd0, lo_out}, {32'd0, exp[31:0]});
    checkVal({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, (op == DIV) && (b == 32'd0)});
    @(posedge clk); #1;
    checkVal({tag, " done width"}, {63'd0, done}, 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [1:0] sgn,
                       input logic [31:0] a, input logic [31:0] b);
    startOp(op, sgn, a, b);
    finishOp(tag, op, sgn, a, b, 0);
  endtask

  task automatic writeHiLo(input logic wHi, input logic wLo, input logic [31:0] d);
    mthi = wHi; mtlo = wLo; wdata = d;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] specials [5];
    specials = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF};
    if ($urandom_range(3) == 0) return specials[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; operation = 4'd0; sign = 2'd0; A = '0; B = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; rd_hi = 1'b0; rd_lo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset hi", {32'd0, hi_out}, 64'd0);
    checkVal("reset lo", {32'd0, lo_out}, 64'd0);
    checkVal("reset busy", {63'd0, busy}, 64'd0);
    checkVal("reset done", {63'd0, done}, 64'd0);
    checkVal("reset div_zero", {63'd0, div_zero}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed operations.
    runOp("umul ffffffff*2", MULT, 2'b00, 32'hFFFF_FFFF, 32'd2);
    runOp("smul -3*7", MULT, 2'b10, 32'hFFFF_FFFD, 32'd7);
    runOp("sdiv -7/2", DIV, 2'b11, 32'hFFFF_FFF9, 32'd2);
    runOp("udiv 100/0", DIV, 2'b00, 32'd100, 32'd0);
    runOp("sdiv -5/0", DIV, 2'b10, 32'hFFFF_FFFB, 32'd0);
    runOp("sdiv min/-1", DIV, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("smul 0*-1", MULT, 2'b10, 32'd0, 32'hFFFF_FFFF);

    // Idle writes, including both at once.
    writeHiLo(1'b1, 1'b0, 32'h1234_5678);
    checkVal("mthi idle", {32'd0, hi_out}, 64'h1234_5678);
    writeHiLo(1'b0, 1'b1, 32'h0BAD_F00D);
    checkVal("mtlo idle", {32'd0, lo_out}, 64'h0BAD_F00D);
    writeHiLo(1'b1, 1'b1, 32'hCAFE_0001);
    checkVal("mthi+mtlo hi", {32'd0, hi_out}, 64'hCAFE_0001);
    checkVal("mthi+mtlo lo", {32'd0, lo_out}, 64'hCAFE_0001);

    // Invalid operation code is ignored.
    start = 1'b1; operation = 4'b0000;
    @(posedge clk); #1;
    start = 1'b0;
    checkVal("bad op busy", {63'd0, busy}, 64'd0);

    // Write in the same cycle as start: lands, then overwritten by the result.
    mthi = 1'b1; wdata = 32'h0000_00AA;
    startOp(MULT, 2'b00, 32'd2, 32'd3);
    checkVal("mthi with start", {32'd0, hi_out}, 64'hAA);
    finishOp("mul after mthi", MULT, 2'b00, 32'd2, 32'd3, 0);

    // Hazard sequence.
    writeHiLo(1'b1, 1'b0, 32'd5);
    startOp(MULT, 2'b00, 32'd3, 32'd4);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rd_hi = 1'b1; mthi = 1'b1; wdata = 32'd9;
    #1;
    checkVal("hazard stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    rd_hi = 1'b0; mthi = 1'b0;
    checkVal("hazard hi held", {32'd0, hi_out}, 64'd5);
    start = 1'b1; operation = DIV; sign = 2'b00; A = 32'd1; B = 32'd0;
    #1;
    checkVal("start busy stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0; operation = 4'd0;
    checkVal("hazard hi still", {32'd0, hi_out}, 64'd5);
    finishOp("hazard mul 3*4", MULT, 2'b00, 32'd3, 32'd4, 12);
    checkVal("stall idle", {63'd0, stall}, 64'd0);

    // Reset in the middle of a divide.
    writeHiLo(1'b1, 1'b1, 32'hDEAD_BEEF);
    startOp(DIV, 2'b10, 32'hFFFF_FC18, 32'd7);
    repeat (15) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checkVal("midop reset busy", {63'd0, busy}, 64'd0);
    checkVal("midop reset done", {63'd0, done}, 64'd0);
    checkVal("midop reset hi", {32'd0, hi_out}, 64'd0);
    checkVal("midop reset lo", {32'd0, lo_out}, 64'd0);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    runOp("sdiv after reset", DIV, 2'b10, 32'hFFFF_FC18, 32'd7);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  op;
      logic [1:0]  sg;
      logic [31:0] a, b;
      op = ($urandom_range(1) == 0) ? MULT : DIV;
      sg = 2'($urandom_range(3));
      a = pickOperand();
      b = pickOperand();
      runOp($sformatf("rand%0d op%0d s%0d %h %h", n, op, sg[1], a, b), op, sg, a, b);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
